// File: rtl/tick_freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in between
// successive one-second ticks and reports the saturated count per window.
module tick_freq_meter #(
   parameter int N = 26
) (
   input  logic         clk,
   input  logic         arst,
   input  logic         en,
   input  logic         tick,
   input  logic         sig_in,
   output logic [N-1:0] count,
   output logic         count_valid,
   output logic         overflow,
   output logic         measuring
);

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   localparam logic [N-1:0] ACC_MAX = {N{1'b1}};
   localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};

   state_t         state_q, state_d;
   logic           s1_q, s2_q, s3_q;
   logic           sig_edge;
   logic           at_max;
   logic [N-1:0]   acc_q, acc_d;
   logic           ovf_acc_q, ovf_acc_d;
   logic [N-1:0]   count_q, count_d;
   logic           overflow_q, overflow_d;
   logic           count_valid_q, count_valid_d;
   logic           measuring_q;

   // s1/s2 resolve metastability; s3 is the history used for edge detection.
   always_ff @(posedge clk) begin
      if (arst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= sig_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign sig_edge = s2_q & ~s3_q;
   assign at_max   = (acc_q == ACC_MAX);

   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      ovf_acc_d     = ovf_acc_q;
      count_d       = count_q;
      overflow_d    = overflow_q;
      count_valid_d = 1'b0;

      if (!en) begin
         state_d   = IDLE;
         acc_d     = '0;
         ovf_acc_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // Partial window before the first tick is discarded.
               if (tick) begin
                  state_d   = MEASURE;
                  acc_d     = '0;
                  ovf_acc_d = 1'b0;
               end
            end
            MEASURE: begin
               if (tick) begin
                  // An edge on the closing tick belongs to the closing window.
                  count_d       = at_max ? ACC_MAX : acc_q + {{(N-1){1'b0}}, sig_edge};
                  overflow_d    = ovf_acc_q | (at_max & sig_edge);
                  count_valid_d = 1'b1;
                  acc_d         = '0;
                  ovf_acc_d     = 1'b0;
               end else if (sig_edge) begin
                  if (at_max) begin
                     ovf_acc_d = 1'b1;
                  end else begin
                     acc_d = acc_q + ONE;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         state_q       <= IDLE;
         acc_q         <= '0;
         ovf_acc_q     <= 1'b0;
         count_q       <= '0;
         overflow_q    <= 1'b0;
         count_valid_q <= 1'b0;
         measuring_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         ovf_acc_q     <= ovf_acc_d;
         count_q       <= count_d;
         overflow_q    <= overflow_d;
         count_valid_q <= count_valid_d;
         measuring_q   <= (state_d == MEASURE);
      end
   end

   assign count       = count_q;
   assign overflow    = overflow_q;
   assign count_valid = count_valid_q;
   assign measuring   = measuring_q;

endmodule

// File: tb/tb_tick_freq_meter.sv
// Bench for tick_freq_meter: two instances (N=8, N=4) share stimulus and are
// compared every cycle against a window-level edge-counting reference.
module tb_tick_freq_meter;

   logic       clk;
   logic       arst;
   logic       en;
   logic       tick;
   logic       sig_in;
   logic [7:0] count8;
   logic       cv8, ovf8, meas8;
   logic [3:0] count4;
   logic       cv4, ovf4, meas4;

   int n_checks;
   int n_fail;

   // Reference state: sampled sig_in history and raw edges in the open window.
   logic       m_h0, m_h1, m_h2;
   bit         m_win;
   int         m_edges;
   logic [7:0] m_cnt8;
   logic [3:0] m_cnt4;
   logic       m_ov8, m_ov4, m_cv;
   logic       s_lvl;

   tick_freq_meter #(.N(8)) dut8 (
      .clk(clk), .arst(arst), .en(en), .tick(tick), .sig_in(sig_in),
      .count(count8), .count_valid(cv8), .overflow(ovf8), .measuring(meas8)
   );

   tick_freq_meter #(.N(4)) dut4 (
      .clk(clk), .arst(arst), .en(en), .tick(tick), .sig_in(sig_in),
      .count(count4), .count_valid(cv4), .overflow(ovf4), .measuring(meas4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, advance the reference at the edge, check at negedge.
   task automatic drive_cycle(input logic t, input logic s, input logic e, input logic r);
      logic ed;
      int   n;
      tick   = t;
      sig_in = s;
      en     = e;
      arst   = r;
      @(posedge clk);
      // A rise sampled two edges ago is seen as an edge at this one.
      ed = m_h1 & ~m_h2;
      if (r) begin
         m_win = 0; m_edges = 0; m_cv = 0;
         m_cnt8 = '0; m_cnt4 = '0; m_ov8 = 0; m_ov4 = 0;
         m_h0 = 0; m_h1 = 0; m_h2 = 0;
      end else begin
         m_h2 = m_h1; m_h1 = m_h0; m_h0 = s;
         m_cv = 0;
         if (!e) begin
            m_win = 0; m_edges = 0;
         end else if (!m_win) begin
            if (t) begin
               m_win = 1; m_edges = 0;
            end
         end else if (t) begin
            n      = m_edges + int'(ed);
            m_cnt8 = (n > 255) ? 8'd255 : 8'(n);
            m_ov8  = (n > 255);
            m_cnt4 = (n > 15) ? 4'd15 : 4'(n);
            m_ov4  = (n > 15);
            m_cv   = 1;
            m_edges = 0;
         end else begin
            m_edges += int'(ed);
         end
      end
      @(negedge clk);
      check_val("count8", 32'(count8), 32'(m_cnt8));
      check_val("ovf8",   32'(ovf8),   32'(m_ov8));
      check_val("cv8",    32'(cv8),    32'(m_cv));
      check_val("meas8",  32'(meas8),  32'(m_win));
      check_val("count4", 32'(count4), 32'(m_cnt4));
      check_val("ovf4",   32'(ovf4),   32'(m_ov4));
      check_val("cv4",    32'(cv4),    32'(m_cv));
      check_val("meas4",  32'(meas4),  32'(m_win));
   endtask

   // Square wave of sig_per cycles (or static high when sig_per==0), tick every tick_per.
   task automatic run_pattern(input int ncyc, input int tick_per, input int sig_per, input logic e);
      logic t, s;
      for (int i = 0; i < ncyc; i++) begin
         t = ((i % tick_per) == tick_per - 1);
         s = (sig_per == 0) ? 1'b1 : ((i % sig_per) < sig_per / 2);
         drive_cycle(t, s, e, 1'b0);
      end
   endtask

   initial begin
      logic [7:0] held;
      int         en_off;
      int         tp;
      n_checks = 0; n_fail = 0;
      m_h0 = 0; m_h1 = 0; m_h2 = 0; m_win = 0; m_edges = 0;
      m_cnt8 = '0; m_cnt4 = '0; m_ov8 = 0; m_ov4 = 0; m_cv = 0;
      tick = 0; sig_in = 0; en = 0; arst = 1;

      drive_cycle(1'b1, 1'b1, 1'b1, 1'b1);
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
      check_val("rst_count", 32'(count8), 32'd0);
      check_val("rst_meas",  32'(meas8),  32'd0);

      // Basic window: 10 edges per 100-cycle window.
      run_pattern(400, 100, 10, 1'b1);
      check_val("basic_count", 32'(count8), 32'd10);
      check_val("basic_ovf",   32'(ovf8),   32'd0);

      // Saturation at N=4, then recovery with a slow signal.
      run_pattern(400, 200, 4, 1'b1);
      check_val("sat_count4", 32'(count4), 32'd15);
      check_val("sat_ovf4",   32'(ovf4),   32'd1);
      check_val("sat_count8", 32'(count8), 32'd50);
      run_pattern(400, 200, 40, 1'b1);
      check_val("rec_count4", 32'(count4), 32'd5);
      check_val("rec_ovf4",   32'(ovf4),   32'd0);

      // Coincident edge: six edges, then a seventh landing on the closing tick.
      for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      drive_cycle(1'b1, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 6; k++) begin
         drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
         for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      end
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
      drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
      drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);
      check_val("coinc_count", 32'(count8), 32'd7);
      check_val("coinc_cv",    32'(cv8),    32'd1);
      for (int i = 0; i < 20; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      drive_cycle(1'b1, 1'b0, 1'b1, 1'b0);
      check_val("coinc_next", 32'(count8), 32'd0);

      // Enable drop for 30 cycles spanning a tick.
      run_pattern(100, 100, 10, 1'b1);
      held = m_cnt8;
      for (int i = 0; i < 30; i++) begin
         drive_cycle(i == 15, (i % 10) < 5, 1'b0, 1'b0);
      end
      check_val("endrop_meas",  32'(meas8),  32'd0);
      check_val("endrop_count", 32'(count8), 32'(held));
      run_pattern(200, 100, 10, 1'b1);
      check_val("enret_count", 32'(count8), 32'd10);

      // Reset mid-window with four edges accumulated.
      run_pattern(40, 100, 10, 1'b1);
      drive_cycle(1'b0, 1'b1, 1'b1, 1'b1);
      check_val("mrst_count", 32'(count8), 32'd0);
      check_val("mrst_ovf",   32'(ovf8),   32'd0);
      check_val("mrst_cv",    32'(cv8),    32'd0);
      check_val("mrst_meas",  32'(meas8),  32'd0);
      run_pattern(100, 100, 10, 1'b1);

      // Static high: the second full window sees no edges.
      run_pattern(100, 100, 0, 1'b1);
      run_pattern(100, 100, 0, 1'b1);
      check_val("static_count", 32'(count8), 32'd0);
      check_val("static_cv",    32'(cv8),    32'd1);

      // Randomized traffic with en drops and occasional resets.
      s_lvl  = 1'b0;
      en_off = 0;
      tp     = 2;
      for (int i = 0; i < 4000; i++) begin
         if ((i % 200) == 0) tp = $urandom_range(1, 6);
         if ($urandom_range(0, tp - 1) == 0) s_lvl = ~s_lvl;
         if (en_off == 0 && $urandom_range(0, 299) == 0) en_off = $urandom_range(5, 30);
         drive_cycle($urandom_range(0, 39) == 0, s_lvl, en_off == 0,
                     $urandom_range(0, 599) == 0);
         if (en_off > 0) en_off--;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
